dds_phase_accumulator: RTL and testbench

//  Phase generator at the front of the DDS chain: drives the 10-bit phase word consumed by the sine

---
 rtl/dds_phase_accumulator_pkg.sv | 13 +
 rtl/dds_sweep_ctrl.sv | 77 +++++++
 rtl/dds_phase_accumulator.sv | 115 +++++++++++
 tb/tb_dds_phase_accumulator.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_phase_accumulator_pkg.sv
// Shared definitions for the DDS phase generator: default widths and the
// chirp controller state encoding.
package dds_phase_accumulator_pkg;

  localparam int unsigned ACC_W_DEF   = 32;
  localparam int unsigned PHASE_W_DEF = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/dds_sweep_ctrl.sv
// Linear chirp controller: owns the active tuning word and ramps it by a fixed
// step per enabled cycle until the stop word is reached.
module dds_sweep_ctrl
  import dds_phase_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             start_i,
  input  logic [ACC_W-1:0] step_i,
  input  logic [ACC_W-1:0] stop_i,
  input  logic             load_i,
  input  logic [ACC_W-1:0] load_ftw_i,
  output logic [ACC_W-1:0] ftw_o,
  output logic             busy_o,
  output logic             busy_next_o
);

  sweep_state_e     state_q, state_d;
  logic [ACC_W-1:0] step_q, step_d;
  logic [ACC_W-1:0] stop_q, stop_d;
  logic [ACC_W-1:0] ftw_q, ftw_d;
  logic [ACC_W:0]   trial;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      stop_q  <= '0;
      ftw_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      stop_q  <= stop_d;
      ftw_q   <= ftw_d;
    end
  end

  // The extra trial bit lets a step that overflows the word still terminate the sweep.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    stop_d  = stop_q;
    ftw_d   = ftw_q;
    trial   = {1'b0, ftw_q} + {1'b0, step_q};
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_SWEEP;
          step_d  = step_i;
          stop_d  = stop_i;
        end
      end
      ST_SWEEP: begin
        if (enable_i) begin
          if (trial >= {1'b0, stop_q}) begin
            ftw_d   = stop_q;
            state_d = ST_IDLE;
          end else begin
            ftw_d = trial[ACC_W-1:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load_i) begin
      ftw_d = load_ftw_i;
    end
  end

  assign ftw_o       = ftw_q;
  assign busy_o      = (state_q == ST_SWEEP);
  assign busy_next_o = (state_d == ST_SWEEP);

endmodule

// File: rtl/dds_phase_accumulator.sv
// DDS phase generator: phase accumulator with static offset, phase-continuous
// tuning-word loading through a one-deep pending register, and a chirp controller.
module dds_phase_accumulator
  import dds_phase_accumulator_pkg::*;
#(
  parameter int unsigned ACC_W        = ACC_W_DEF,
  parameter int unsigned PHASE_W      = PHASE_W_DEF,
  parameter bit          LOAD_ON_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ACC_W-1:0]   ftw_in,
  input  logic               ftw_valid,
  output logic               ftw_ready,
  input  logic [PHASE_W-1:0] offset_in,
  input  logic               sweep_start,
  input  logic [ACC_W-1:0]   sweep_step,
  input  logic [ACC_W-1:0]   sweep_stop,
  output logic               sweep_busy,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap
);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   pend_ftw_q, pend_ftw_d;
  logic               pend_valid_q, pend_valid_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q, phase_valid_d;
  logic               wrap_q, wrap_d;
  logic               ftw_ready_q, ftw_ready_d;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   ftw_act;
  logic               accept;
  logic               start_ok;
  logic               load_ftw;
  logic               busy;
  logic               busy_next;

  dds_sweep_ctrl #(
    .ACC_W(ACC_W)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .enable_i   (enable),
    .start_i    (start_ok),
    .step_i     (sweep_step),
    .stop_i     (sweep_stop),
    .load_i     (load_ftw),
    .load_ftw_i (pend_ftw_q),
    .ftw_o      (ftw_act),
    .busy_o     (busy),
    .busy_next_o(busy_next)
  );

  // ftw_ready_q already encodes "idle with nothing pending", so it gates both requests;
  // a simultaneous tuning-word offer wins over a sweep start.
  always_comb begin
    sum      = {1'b0, acc_q} + {1'b0, ftw_act};
    accept   = ftw_valid & ftw_ready_q;
    start_ok = sweep_start & ftw_ready_q & ~ftw_valid;
    load_ftw = enable & pend_valid_q & (LOAD_ON_WRAP ? sum[ACC_W] : 1'b1);
  end

  always_comb begin
    acc_d         = acc_q;
    phase_d       = phase_q;
    phase_valid_d = 1'b0;
    wrap_d        = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_ftw_d    = pend_ftw_q;
    if (enable) begin
      acc_d         = sum[ACC_W-1:0];
      phase_d       = sum[ACC_W-1 -: PHASE_W] + offset_in;
      phase_valid_d = 1'b1;
      wrap_d        = sum[ACC_W];
    end
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_ftw_d   = ftw_in;
    end else if (load_ftw) begin
      pend_valid_d = 1'b0;
    end
    ftw_ready_d = ~busy_next & ~pend_valid_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q         <= '0;
      pend_ftw_q    <= '0;
      pend_valid_q  <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      ftw_ready_q   <= 1'b1;
    end else begin
      acc_q         <= acc_d;
      pend_ftw_q    <= pend_ftw_d;
      pend_valid_q  <= pend_valid_d;
      phase_q       <= phase_d;
      phase_valid_q <= phase_valid_d;
      wrap_q        <= wrap_d;
      ftw_ready_q   <= ftw_ready_d;
    end
  end

  assign ftw_ready   = ftw_ready_q;
  assign sweep_busy  = busy;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Bench for dds_phase_accumulator: two instances (load-on-wrap and load-immediately)
// checked every cycle against an arithmetic model, plus hand-computed expectations.
module tb_dds_phase_accumulator;

  localparam int unsigned SHIFT = 22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] ftwIn = '0;
  logic        ftwValid = 1'b0;
  logic [9:0]  offsetIn = '0;
  logic        sweepStart = 1'b0;
  logic [31:0] sweepStep = '0;
  logic [31:0] sweepStop = '0;

  logic [9:0]  phaseOut [2];
  logic        phaseValidOut [2];
  logic        wrapOut [2];
  logic        readyOut [2];
  logic        busyOut [2];

  int assertCount = 0;
  int failCount = 0;

  // Instance 0 loads on wrap, instance 1 loads on the next enabled edge.
  const bit loadOnWrap [2] = '{1'b1, 1'b0};
  longint unsigned mAcc [2], mFtw [2], mPend [2], mStep [2], mStop [2], mPhase [2];
  bit mPendV [2], mBusy [2], mPv [2], mWrap [2], mReady [2];

  int expPh [5] = '{256, 512, 768, 0, 256};
  bit expWr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  dds_phase_accumulator #(.ACC_W(32), .PHASE_W(10), .LOAD_ON_WRAP(1'b1)) uA (
    .clk(clk), .reset(reset), .enable(enable), .ftw_in(ftwIn), .ftw_valid(ftwValid),
    .ftw_ready(readyOut[0]), .offset_in(offsetIn), .sweep_start(sweepStart),
    .sweep_step(sweepStep), .sweep_stop(sweepStop), .sweep_busy(busyOut[0]),
    .phase(phaseOut[0]), .phase_valid(phaseValidOut[0]), .wrap(wrapOut[0])
  );

  dds_phase_accumulator #(.ACC_W(32), .PHASE_W(10), .LOAD_ON_WRAP(1'b0)) uB (
    .clk(clk), .reset(reset), .enable(enable), .ftw_in(ftwIn), .ftw_valid(ftwValid),
    .ftw_ready(readyOut[1]), .offset_in(offsetIn), .sweep_start(sweepStart),
    .sweep_step(sweepStep), .sweep_stop(sweepStop), .sweep_busy(busyOut[1]),
    .phase(phaseOut[1]), .phase_valid(phaseValidOut[1]), .wrap(wrapOut[1])
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mAcc[i] = 0; mFtw[i] = 0; mPend[i] = 0; mStep[i] = 0; mStop[i] = 0; mPhase[i] = 0;
      mPendV[i] = 0; mBusy[i] = 0; mPv[i] = 0; mWrap[i] = 0; mReady[i] = 1;
    end
  endtask

  task automatic modelStep();
    longint unsigned total, trial;
    bit carry, accept, start;
    for (int i = 0; i < 2; i++) begin
      accept = ftwValid && mReady[i];
      start  = sweepStart && mReady[i] && !ftwValid;
      if (enable) begin
        total = mAcc[i] + mFtw[i];
        carry = (total >= 64'h1_0000_0000);
        mAcc[i] = total % 64'h1_0000_0000;
        mPhase[i] = ((mAcc[i] >> SHIFT) + 64'(offsetIn)) % 1024;
        mWrap[i] = carry;
        mPv[i] = 1'b1;
        if (mBusy[i]) begin
          trial = mFtw[i] + mStep[i];
          if (trial >= mStop[i]) begin
            mFtw[i] = mStop[i];
            mBusy[i] = 1'b0;
          end else begin
            mFtw[i] = trial;
          end
        end
        if (mPendV[i] && (!loadOnWrap[i] || carry)) begin
          mFtw[i] = mPend[i];
          mPendV[i] = 1'b0;
        end
      end else begin
        mPv[i] = 1'b0;
        mWrap[i] = 1'b0;
      end
      if (accept) begin
        mPend[i] = 64'(ftwIn);
        mPendV[i] = 1'b1;
      end
      if (start) begin
        mBusy[i] = 1'b1;
        mStep[i] = 64'(sweepStep);
        mStop[i] = 64'(sweepStop);
      end
      mReady[i] = !mBusy[i] && !mPendV[i];
    end
  endtask

  // Model advances on every clock/reset event; outputs are compared just after.
  always @(posedge clk or negedge reset) begin
    if (!reset) modelReset();
    else modelStep();
    #1;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("model phase[%0d]", i), 64'(phaseOut[i]), mPhase[i]);
      checkOutput($sformatf("model phase_valid[%0d]", i), 64'(phaseValidOut[i]), 64'(mPv[i]));
      checkOutput($sformatf("model wrap[%0d]", i), 64'(wrapOut[i]), 64'(mWrap[i]));
      checkOutput($sformatf("model ftw_ready[%0d]", i), 64'(readyOut[i]), 64'(mReady[i]));
      checkOutput($sformatf("model sweep_busy[%0d]", i), 64'(busyOut[i]), 64'(mBusy[i]));
    end
  end

  task automatic applyStimulus(input logic en, input logic fv, input logic [31:0] fin,
                               input logic ss, input logic [31:0] step, input logic [31:0] stop);
    @(negedge clk);
    enable = en; ftwValid = fv; ftwIn = fin;
    sweepStart = ss; sweepStep = step; sweepStop = stop;
    @(posedge clk);
    #2;
  endtask

  task automatic runCycle(input logic en);
    applyStimulus(en, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    enable = 0; ftwValid = 0; ftwIn = '0; sweepStart = 0;
    sweepStep = '0; sweepStop = '0; offsetIn = '0;
    reset = 1'b0;
    #2;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("%s async phase[%0d]", tag, i), 64'(phaseOut[i]), 64'd0);
      checkOutput($sformatf("%s async busy[%0d]", tag, i), 64'(busyOut[i]), 64'd0);
      checkOutput($sformatf("%s async ready[%0d]", tag, i), 64'(readyOut[i]), 64'd1);
      checkOutput($sformatf("%s async pvalid[%0d]", tag, i), 64'(phaseValidOut[i]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1 reset = 1'b0;
    runCycle(1'b0);
    runCycle(1'b0);
    checkOutput("reset phase", 64'(phaseOut[0]), 64'd0);
    checkOutput("reset phase_valid", 64'(phaseValidOut[0]), 64'd0);
    checkOutput("reset wrap", 64'(wrapOut[0]), 64'd0);
    checkOutput("reset ready", 64'(readyOut[0]), 64'd1);
    checkOutput("reset busy", 64'(busyOut[0]), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] FTW 0x40000000 via one-step sweep, then free run");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h4000_0000, 32'h4000_0000);
    checkOutput("t1 busy after start", 64'(busyOut[0]), 64'd1);
    checkOutput("t1 ready after start", 64'(readyOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t1 first phase", 64'(phaseOut[0]), 64'd0);
    checkOutput("t1 busy done", 64'(busyOut[0]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      runCycle(1'b1);
      checkOutput($sformatf("t1 phase %0d", k), 64'(phaseOut[0]), 64'(expPh[k]));
      checkOutput($sformatf("t1 wrap %0d", k), 64'(wrapOut[0]), 64'(expWr[k]));
    end

    $display("[TB] FTW reload to 0x20000000 while running");
    applyStimulus(1'b1, 1'b1, 32'h2000_0000, 1'b0, 32'h0, 32'h0);
    checkOutput("t3 phase accept", 64'(phaseOut[0]), 64'd512);
    checkOutput("t3 ready accept", 64'(readyOut[0]), 64'd0);
    applyStimulus(1'b1, 1'b1, 32'h2000_0000, 1'b0, 32'h0, 32'h0);
    checkOutput("t3 phase 768", 64'(phaseOut[0]), 64'd768);
    checkOutput("t3 ready held low", 64'(readyOut[0]), 64'd0);
    checkOutput("t3 immediate ready", 64'(readyOut[1]), 64'd1);
    runCycle(1'b1);
    checkOutput("t3 phase wrap", 64'(phaseOut[0]), 64'd0);
    checkOutput("t3 wrap flag", 64'(wrapOut[0]), 64'd1);
    checkOutput("t3 ready after wrap", 64'(readyOut[0]), 64'd1);
    checkOutput("t3 immediate phase", 64'(phaseOut[1]), 64'd896);
    runCycle(1'b1);
    checkOutput("t3 phase new ftw", 64'(phaseOut[0]), 64'd128);
    runCycle(1'b1);
    checkOutput("t3 phase new ftw 2", 64'(phaseOut[0]), 64'd256);

    applyStimulus(1'b1, 1'b1, 32'h0800_0000, 1'b1, 32'h1, 32'hFFFF_FFFF);
    checkOutput("start with ftw dropped", 64'(busyOut[0]), 64'd0);
    checkOutput("ftw accepted over start", 64'(readyOut[0]), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFF);
    checkOutput("start while pending A", 64'(busyOut[0]), 64'd0);
    checkOutput("start while pending B", 64'(busyOut[1]), 64'd0);
    for (int k = 0; k < 6; k++) runCycle(1'b1);

    $display("[TB] offset wrap");
    doReset("pre-offset");
    offsetIn = 10'h3FF;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0000, 32'h0040_0000);
    checkOutput("t2 held phase", 64'(phaseOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t2 phase offset only", 64'(phaseOut[0]), 64'h3FF);
    for (int k = 0; k < 3; k++) begin
      runCycle(1'b1);
      checkOutput($sformatf("t2 phase %0d", k), 64'(phaseOut[0]), 64'(k));
    end

    applyStimulus(1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0);
    checkOutput("t6 pending A", 64'(readyOut[0]), 64'd0);
    checkOutput("t6 pending B", 64'(readyOut[1]), 64'd0);
    runCycle(1'b0);
    doReset("pending");
    runCycle(1'b1);
    checkOutput("t6 phase A after reset", 64'(phaseOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t6 pending discarded B", 64'(phaseOut[1]), 64'd0);
    checkOutput("t6 phase_valid", 64'(phaseValidOut[0]), 64'd1);

    $display("[TB] chirp with enable gap");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h1000_0000, 32'h3800_0000);
    checkOutput("t4 busy start", 64'(busyOut[0]), 64'd1);
    runCycle(1'b1);
    checkOutput("t4 phase s1", 64'(phaseOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t4 phase s2", 64'(phaseOut[0]), 64'd64);
    runCycle(1'b0);
    checkOutput("t5 phase frozen", 64'(phaseOut[0]), 64'd64);
    checkOutput("t5 phase_valid low", 64'(phaseValidOut[0]), 64'd0);
    checkOutput("t5 busy held", 64'(busyOut[0]), 64'd1);
    runCycle(1'b1);
    checkOutput("t4 phase s3", 64'(phaseOut[0]), 64'd192);
    checkOutput("t4 busy s3", 64'(busyOut[0]), 64'd1);
    runCycle(1'b1);
    checkOutput("t4 phase s4", 64'(phaseOut[0]), 64'd384);
    checkOutput("t4 busy cleared", 64'(busyOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t4 phase stop ftw", 64'(phaseOut[0]), 64'd608);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hF000_0000, 32'hFFFF_FFF0);
    runCycle(1'b1);
    checkOutput("overflow sweep done", 64'(busyOut[0]), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0000_0100);
    runCycle(1'b0);
    checkOutput("zero step waits enable", 64'(busyOut[0]), 64'd1);
    runCycle(1'b1);
    checkOutput("zero step done", 64'(busyOut[0]), 64'd0);
    for (int k = 0; k < 3; k++) runCycle(1'b1);

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0100_0000, 32'hF000_0000);
    runCycle(1'b1);
    runCycle(1'b1);
    checkOutput("t6 mid-sweep busy", 64'(busyOut[0]), 64'd1);
    doReset("mid-sweep");
    runCycle(1'b1);
    checkOutput("t6 first phase", 64'(phaseOut[0]), 64'd0);
    runCycle(1'b1);
    checkOutput("t6 second phase", 64'(phaseOut[0]), 64'd0);
    runCycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
